// File: rtl/main_pkg.sv
// -----------------------------------------------------------------------------
// main_pkg
// Shared constants, types and ROM content for the 64 x 8 lookup table.
//   ADDR_W / DATA_W / DEPTH : geometry of the table
//   addr_t / data_t         : address and data word types
//   ROM_INIT                : the 64 constant entries, ROM[i] = {i,2'b00} ^ 8'h5A
// -----------------------------------------------------------------------------
package main_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;

    typedef logic [5:0] addr_t;
    typedef logic [7:0] data_t;

    // Literal table so that synthesis sees pure constant content (LUT-ROM),
    // with no arithmetic in the read datapath.
    localparam data_t ROM_INIT [DEPTH] = '{
        8'h5A, 8'h5E, 8'h52, 8'h56,  8'h4A, 8'h4E, 8'h42, 8'h46,
        8'h7A, 8'h7E, 8'h72, 8'h76,  8'h6A, 8'h6E, 8'h62, 8'h66,
        8'h1A, 8'h1E, 8'h12, 8'h16,  8'h0A, 8'h0E, 8'h02, 8'h06,
        8'h3A, 8'h3E, 8'h32, 8'h36,  8'h2A, 8'h2E, 8'h22, 8'h26,
        8'hDA, 8'hDE, 8'hD2, 8'hD6,  8'hCA, 8'hCE, 8'hC2, 8'hC6,
        8'hFA, 8'hFE, 8'hF2, 8'hF6,  8'hEA, 8'hEE, 8'hE2, 8'hE6,
        8'h9A, 8'h9E, 8'h92, 8'h96,  8'h8A, 8'h8E, 8'h82, 8'h86,
        8'hBA, 8'hBE, 8'hB2, 8'hB6,  8'hAA, 8'hAE, 8'hA2, 8'hA6
    };

endpackage : main_pkg

// File: rtl/main_rom_core.sv
// -----------------------------------------------------------------------------
// main_rom_core
// Purely combinational lookup into the constant table.
//   addr : in  addr_t  read address (fully decoded, every value is valid)
//   data : out data_t  ROM_INIT[addr]
// -----------------------------------------------------------------------------
module main_rom_core
    import main_pkg::*;
(
    input  addr_t addr,
    output data_t data
);

    assign data = ROM_INIT[addr];

endmodule : main_rom_core

// File: rtl/main.sv
// -----------------------------------------------------------------------------
// main
// 64 x 8 read-only lookup table with constant content.
// Default build: registered read, 1-cycle latency, output cleared
// asynchronously while reset is low.
// With MAIN_ASYNC_READ_EN defined: combinational read, 0-cycle latency,
// reset has no effect on data (port kept for interface compatibility).
//   clock : in  1       rising-edge clock
//   reset : in  1       asynchronous active-low reset
//   addr  : in  ADDR_W  read address, sampled every cycle
//   data  : out DATA_W  ROM word for addr
// -----------------------------------------------------------------------------
module main #(
    parameter int ADDR_W = main_pkg::ADDR_W,
    parameter int DATA_W = main_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    import main_pkg::*;

    // The content table only exists for the 6-bit / 8-bit geometry.
    if (ADDR_W != 6 || DATA_W != 8) begin : g_bad_geometry
        $error("main: only ADDR_W=6 and DATA_W=8 are supported (got %0d/%0d)",
               ADDR_W, DATA_W);
    end

    data_t rom_data;

    main_rom_core u_rom_core (
        .addr (addr),
        .data (rom_data)
    );

`ifdef MAIN_ASYNC_READ_EN

    assign data = rom_data;

`else

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        data_d = rom_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

`endif

    // An unknown address would otherwise silently produce an unknown word.
    a_addr_known : assert property (@(posedge clock) disable iff (!reset)
                                    !$isunknown(addr))
        else $error("main: addr is X/Z while out of reset");

endmodule : main

// File: tb/tb_main.sv
// -----------------------------------------------------------------------------
// tb_main
// Self-checking bench for main. Reference content is computed from the
// table rule {addr,2'b00} ^ 8'h5A; expected words flow through exp_q.
// -----------------------------------------------------------------------------
module tb_main;

    logic       clock;
    logic       reset;
    logic [5:0] addr;
    logic [7:0] data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    main dut (
        .clock (clock),
        .reset (reset),
        .addr  (addr),
        .data  (data)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic logic [7:0] rom_ref(input int a);
        int v;
        v = ((a % 64) * 4) ^ 'h5A;
        return v[7:0];
    endfunction

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [7:0] obs,
                            input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; drives one cycle of stimulus and
    // checks the output at the following falling edge.
    task automatic drive_cycle(input string tag, input logic [5:0] a,
                               input logic r);
        addr  = a;
        reset = r;
`ifdef MAIN_ASYNC_READ_EN
        #1;
        check_eq(tag, data, rom_ref(int'(a)));
        @(posedge clock);
        @(negedge clock);
`else
        @(posedge clock);
        exp_q.push_back(r ? rom_ref(int'(a)) : 8'h00);
        @(negedge clock);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_noexp"}, data, 8'hxx);
        end else begin
            check_eq(tag, data, exp_q.pop_front());
        end
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] ra;
        logic       rr;

        reset = 1'b0;
        addr  = 6'd0;
        @(negedge clock);
`ifndef MAIN_ASYNC_READ_EN
        check_eq("reset_init", data, 8'h00);
`endif

        // Reset held for 3 cycles while the address toggles.
        for (int i = 0; i < 3; i++) begin
            drive_cycle("reset_hold", (i % 2 == 0) ? 6'h2A : 6'h15, 1'b0);
        end

        // Sweep from 0 past the wrap point back into the low addresses.
        for (int i = 0; i < 70; i++) begin
            ra = 6'(i);
            if (i == 63)      drive_cycle("wrap_3f", ra, 1'b1);
            else if (i == 64) drive_cycle("wrap_00", ra, 1'b1);
            else              drive_cycle("sweep", ra, 1'b1);
        end

        // Mid-operation reset at addr 10, asserted between clock edges.
        drive_cycle("pre_mid_rst", 6'd10, 1'b1);
        #2;
        reset = 1'b0;
        #1;
`ifdef MAIN_ASYNC_READ_EN
        check_eq("mid_rst_async", data, rom_ref(10));
`else
        check_eq("mid_rst_async", data, 8'h00);
`endif
        @(negedge clock);
        drive_cycle("mid_rst_hold", 6'd10, 1'b0);
        drive_cycle("mid_rst_release", 6'd10, 1'b1);
        drive_cycle("mid_rst_next", 6'd11, 1'b1);

        // Random addresses with occasional reset pulses.
        for (int i = 0; i < 250; i++) begin
            ra = 6'($urandom_range(0, 63));
            rr = ($urandom_range(0, 31) != 0);
            drive_cycle(rr ? "random" : "random_rst", ra, rr);
        end

        check_eq("queue_empty", 8'(exp_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Overall time limit so the bench can never hang.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_main
